// File: rtl/alu_sequencer_if.sv
// Request/response handshake bundle between the decode stage and the ALU sequencer.
interface alu_sequencer_if #(
  parameter int unsigned xlen = 64
) ();
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [xlen-1:0] req_a;
  logic [xlen-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [xlen-1:0] rsp_result;
  logic            rsp_taken;
  logic            rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_taken, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_taken, rsp_err
  );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle requester for the combinational ALU: encodes the op, holds operands
// for settle_cycles, captures result/zero and returns them over a response handshake.
module alu_sequencer #(
  parameter int unsigned xlen          = 64,
  parameter int unsigned settle_cycles = 1
) (
  input  logic            clk,
  input  logic            rst,
  alu_sequencer_if.slave  bus,
  output logic [xlen-1:0] alu_a,
  output logic [xlen-1:0] alu_b,
  output logic [2:0]      alu_ctrl,
  input  logic [xlen-1:0] alu_result,
  input  logic            alu_zero
);

  localparam int unsigned cnt_w = 4;

  localparam logic [2:0] op_and = 3'd0;
  localparam logic [2:0] op_or  = 3'd1;
  localparam logic [2:0] op_add = 3'd2;
  localparam logic [2:0] op_sub = 3'd3;
  localparam logic [2:0] op_slt = 3'd4;
  localparam logic [2:0] op_beq = 3'd5;
  localparam logic [2:0] op_bne = 3'd6;
  localparam logic [2:0] op_ill = 3'd7;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state, state_nxt;
  logic [cnt_w-1:0]  cnt, cnt_nxt;
  logic [2:0]        op_q, op_nxt;
  logic [xlen-1:0]   alu_a_nxt, alu_b_nxt;
  logic [2:0]        alu_ctrl_nxt;
  logic [xlen-1:0]   rsp_result_q, rsp_result_nxt;
  logic              rsp_taken_q, rsp_taken_nxt;
  logic              rsp_err_q, rsp_err_nxt;
  logic              req_ready_q, rsp_valid_q;

  // Branches compare by subtraction; 100/101 are never produced.
  function automatic logic [2:0] encode(input logic [2:0] op);
    case (op)
      op_and:                 encode = 3'b000;
      op_or:                  encode = 3'b001;
      op_add:                 encode = 3'b010;
      op_sub, op_beq, op_bne: encode = 3'b110;
      op_slt:                 encode = 3'b111;
      default:                encode = 3'b000;
    endcase
  endfunction

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    op_nxt         = op_q;
    alu_a_nxt      = alu_a;
    alu_b_nxt      = alu_b;
    alu_ctrl_nxt   = alu_ctrl;
    rsp_result_nxt = rsp_result_q;
    rsp_taken_nxt  = rsp_taken_q;
    rsp_err_nxt    = rsp_err_q;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_op == op_ill) begin
            rsp_result_nxt = '0;
            rsp_taken_nxt  = 1'b0;
            rsp_err_nxt    = 1'b1;
            state_nxt      = RESP;
          end else begin
            alu_a_nxt    = bus.req_a;
            alu_b_nxt    = bus.req_b;
            alu_ctrl_nxt = encode(bus.req_op);
            op_nxt       = bus.req_op;
            cnt_nxt      = cnt_w'(settle_cycles - 1);
            state_nxt    = EXEC;
          end
        end
      end
      EXEC: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - cnt_w'(1);
        end else begin
          rsp_result_nxt = alu_result;
          rsp_err_nxt    = 1'b0;
          rsp_taken_nxt  = (op_q == op_beq) ? alu_zero
                         : (op_q == op_bne) ? ~alu_zero
                         : 1'b0;
          state_nxt      = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake flags are registered copies of the next-state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      op_q         <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_ctrl     <= 3'b000;
      rsp_result_q <= '0;
      rsp_taken_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      op_q         <= op_nxt;
      alu_a        <= alu_a_nxt;
      alu_b        <= alu_b_nxt;
      alu_ctrl     <= alu_ctrl_nxt;
      rsp_result_q <= rsp_result_nxt;
      rsp_taken_q  <= rsp_taken_nxt;
      rsp_err_q    <= rsp_err_nxt;
      req_ready_q  <= (state_nxt == IDLE);
      rsp_valid_q  <= (state_nxt == RESP);
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_taken  = rsp_taken_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: default settle instance plus a settle_cycles=3 instance.
module tb_alu_sequencer;

  logic clk;
  logic rst1, rst3;
  int   compared;
  int   mismatched;
  int   n;

  alu_sequencer_if #(.xlen(64)) bus1 ();
  alu_sequencer_if #(.xlen(64)) bus3 ();

  logic [63:0] alu_a1, alu_b1, alu_res1;
  logic [2:0]  ctrl1;
  logic        zero1;
  logic [63:0] alu_a3, alu_b3, alu_res3;
  logic [2:0]  ctrl3;
  logic        zero3;

  // Behavioural stand-in for the combinational ALU.
  function automatic logic [63:0] alu_f(input logic [63:0] a, input logic [63:0] b,
                                        input logic [2:0] c);
    logic [63:0] d;
    d = a - b;
    case (c)
      3'b000:  alu_f = a & b;
      3'b001:  alu_f = a | b;
      3'b010:  alu_f = a + b;
      3'b110:  alu_f = d;
      3'b111:  alu_f = {63'd0, d[63]};
      default: alu_f = 64'd0;
    endcase
  endfunction

  assign alu_res1 = alu_f(alu_a1, alu_b1, ctrl1);
  assign zero1    = (alu_res1 == 64'd0);
  assign alu_res3 = alu_f(alu_a3, alu_b3, ctrl3);
  assign zero3    = (alu_res3 == 64'd0);

  alu_sequencer #(.xlen(64), .settle_cycles(1)) u1 (
    .clk(clk), .rst(rst1), .bus(bus1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_ctrl(ctrl1),
    .alu_result(alu_res1), .alu_zero(zero1)
  );

  alu_sequencer #(.xlen(64), .settle_cycles(3)) u3 (
    .clk(clk), .rst(rst3), .bus(bus3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_ctrl(ctrl3),
    .alu_result(alu_res3), .alu_zero(zero3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request on instance u1 with rsp_ready asserted once the response appears.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [2:0] exp_ctrl,
                        input logic [63:0] exp_res, input logic exp_taken,
                        input logic exp_err);
    int k;
    bus1.req_valid = 1'b1;
    bus1.req_op    = op;
    bus1.req_a     = a;
    bus1.req_b     = b;
    bus1.rsp_ready = 1'b0;
    tick();
    bus1.req_valid = 1'b0;
    if (!exp_err) check({tag, ".ctrl"}, 64'(ctrl1), 64'(exp_ctrl));
    k = 0;
    while (bus1.rsp_valid !== 1'b1 && k < 16) begin
      tick();
      k++;
    end
    check({tag, ".latency"}, 64'(k), exp_err ? 64'd0 : 64'd1);
    check({tag, ".result"}, bus1.rsp_result, exp_res);
    check({tag, ".taken"}, 64'(bus1.rsp_taken), 64'(exp_taken));
    check({tag, ".err"}, 64'(bus1.rsp_err), 64'(exp_err));
    check({tag, ".req_ready_busy"}, 64'(bus1.req_ready), 64'd0);
    bus1.rsp_ready = 1'b1;
    tick();
    bus1.rsp_ready = 1'b0;
    check({tag, ".rsp_valid_done"}, 64'(bus1.rsp_valid), 64'd0);
    check({tag, ".req_ready_done"}, 64'(bus1.req_ready), 64'd1);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst1 = 1'b1;
    rst3 = 1'b1;
    bus1.req_valid = 1'b0; bus1.req_op = 3'd0; bus1.req_a = 64'd0; bus1.req_b = 64'd0;
    bus1.rsp_ready = 1'b0;
    bus3.req_valid = 1'b0; bus3.req_op = 3'd0; bus3.req_a = 64'd0; bus3.req_b = 64'd0;
    bus3.rsp_ready = 1'b0;
    tick();
    tick();
    rst1 = 1'b0;
    rst3 = 1'b0;

    check("reset.req_ready", 64'(bus1.req_ready), 64'd1);
    check("reset.rsp_valid", 64'(bus1.rsp_valid), 64'd0);
    check("reset.alu_a", alu_a1, 64'd0);
    check("reset.alu_b", alu_b1, 64'd0);
    check("reset.alu_ctrl", 64'(ctrl1), 64'd0);
    check("reset.rsp_result", bus1.rsp_result, 64'd0);
    check("reset.rsp_err", 64'(bus1.rsp_err), 64'd0);

    run_op("add", 3'd2, 64'd5, 64'd7, 3'b010, 64'd12, 1'b0, 1'b0);
    run_op("sub", 3'd3, 64'd3, 64'd5, 3'b110, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    run_op("slt", 3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b111, 64'd1, 1'b0, 1'b0);
    run_op("and", 3'd0, 64'hF0F0, 64'hFF00, 3'b000, 64'hF000, 1'b0, 1'b0);
    run_op("beq_eq", 3'd5, 64'h40, 64'h40, 3'b110, 64'd0, 1'b1, 1'b0);
    run_op("bne_eq", 3'd6, 64'h40, 64'h40, 3'b110, 64'd0, 1'b0, 1'b0);
    run_op("bne_ne", 3'd6, 64'd1, 64'd2, 3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);

    // Illegal op leaves the ALU inputs from the previous BNE untouched.
    run_op("ill", 3'd7, 64'hDEAD, 64'hBEEF, 3'b000, 64'd0, 1'b0, 1'b1);
    check("ill.alu_a_held", alu_a1, 64'd1);
    check("ill.alu_b_held", alu_b1, 64'd2);
    check("ill.alu_ctrl_held", 64'(ctrl1), 64'(3'b110));

    // Backpressure with the next request already waiting.
    bus1.req_valid = 1'b1; bus1.req_op = 3'd2; bus1.req_a = 64'd1; bus1.req_b = 64'd2;
    bus1.rsp_ready = 1'b0;
    tick();
    bus1.req_op = 3'd1; bus1.req_a = 64'h0F; bus1.req_b = 64'hF0;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("bp.rsp_valid", 64'(bus1.rsp_valid), 64'd1);
      check("bp.rsp_result", bus1.rsp_result, 64'd3);
      check("bp.req_ready", 64'(bus1.req_ready), 64'd0);
      tick();
    end
    check("bp.rsp_result_after", bus1.rsp_result, 64'd3);
    bus1.rsp_ready = 1'b1;
    tick();
    check("bp.hs_req_ready", 64'(bus1.req_ready), 64'd1);
    check("bp.hs_rsp_valid", 64'(bus1.rsp_valid), 64'd0);
    tick();
    bus1.req_valid = 1'b0;
    check("bp.next_accepted", 64'(bus1.req_ready), 64'd0);
    check("bp.next_ctrl", 64'(ctrl1), 64'(3'b001));
    check("bp.next_alu_a", alu_a1, 64'h0F);
    tick();
    check("bp.or_valid", 64'(bus1.rsp_valid), 64'd1);
    check("bp.or_result", bus1.rsp_result, 64'hFF);
    tick();
    check("bp.or_done", 64'(bus1.rsp_valid), 64'd0);
    bus1.rsp_ready = 1'b0;

    // settle_cycles=3: reset during the second EXEC cycle drops the request.
    bus3.req_valid = 1'b1; bus3.req_op = 3'd2; bus3.req_a = 64'd10; bus3.req_b = 64'd20;
    tick();
    bus3.req_valid = 1'b0;
    check("s3.inflight_ctrl", 64'(ctrl3), 64'(3'b010));
    tick();
    check("s3.still_exec", 64'(bus3.rsp_valid), 64'd0);
    rst3 = 1'b1;
    tick();
    rst3 = 1'b0;
    check("s3.rst_req_ready", 64'(bus3.req_ready), 64'd1);
    check("s3.rst_rsp_valid", 64'(bus3.rsp_valid), 64'd0);
    check("s3.rst_alu_a", alu_a3, 64'd0);
    check("s3.rst_alu_b", alu_b3, 64'd0);
    check("s3.rst_alu_ctrl", 64'(ctrl3), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("s3.no_rsp", 64'(bus3.rsp_valid), 64'd0);
    end

    bus3.req_valid = 1'b1; bus3.req_op = 3'd2; bus3.req_a = 64'd100; bus3.req_b = 64'd23;
    bus3.rsp_ready = 1'b0;
    tick();
    bus3.req_valid = 1'b0;
    n = 0;
    while (bus3.rsp_valid !== 1'b1 && n < 16) begin
      tick();
      n++;
    end
    check("s3.latency", 64'(n), 64'd3);
    check("s3.result", bus3.rsp_result, 64'd123);
    check("s3.err", 64'(bus3.rsp_err), 64'd0);
    bus3.rsp_ready = 1'b1;
    tick();
    bus3.rsp_ready = 1'b0;
    check("s3.done", 64'(bus3.rsp_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
